// File: rtl/tdc_sample_packer_pkg.sv
// Shared definitions for the TDC sample packer.
// This package holds the widths, word tags, FSM encoding and word-packing helpers.
package tdc_sample_packer_pkg;

    localparam int SAFF_W    = 21;
    localparam int DOUT_W    = 7;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 16;
    localparam int SEL_W     = 4;
    localparam int FINE_W    = 5;
    localparam int NSAMP_W   = 4;
    localparam int SAFF_LO_W = 16;
    localparam int SAFF_HI_W = SAFF_W - SAFF_LO_W;

    localparam logic [1:0]         TAG_WORD0       = 2'b10;
    localparam logic [1:0]         TAG_WORD2       = 2'b11;
    localparam logic [3:0]         HEADER_MAGIC    = 4'hA;
    localparam logic [NSAMP_W-1:0] MAX_SAMPLES     = 4'd10;
    localparam logic [ADDR_W-1:0]  HEADER_ADDR     = 5'd0;
    localparam logic [ADDR_W-1:0]  FIRST_DATA_ADDR = 5'd1;
    localparam logic [ADDR_W-1:0]  WORDS_PER_SAMP  = 5'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_E0    = 3'd2,
        ST_E1    = 3'd3,
        ST_E2    = 3'd4,
        ST_HDR   = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // First word of a sample: tag, structure select and coarse count.
    function automatic logic [DATA_W-1:0] pack_word0(input logic [SEL_W-1:0]  sel,
                                                     input logic [DOUT_W-1:0] dout);
        return {TAG_WORD0, sel, 3'b000, dout};
    endfunction

    // Third word of a sample: tag, bubble flag, decoded fine code and the SAFF upper bits.
    function automatic logic [DATA_W-1:0] pack_word2(input logic                 bubble,
                                                     input logic [FINE_W-1:0]    fine,
                                                     input logic [SAFF_HI_W-1:0] saff_hi);
        return {TAG_WORD2, bubble, fine, 3'b000, saff_hi};
    endfunction

    // Frame header read back by the host: magic, overflow flag and sample count.
    function automatic logic [DATA_W-1:0] pack_header(input logic               ovf,
                                                      input logic [NSAMP_W-1:0] nsamp);
        return {HEADER_MAGIC, 2'b00, ovf, 5'b00000, nsamp};
    endfunction

endpackage

// File: rtl/tdc_sample_packer_if.sv
// Bundle between the sequencer, the packer and the datamem write port.
// The master side is the packer: it consumes the readout strobes and drives the write port and status.
interface tdc_sample_packer_if;
    import tdc_sample_packer_pkg::*;

    logic                 start;
    logic                 sample;
    logic [SEL_W-1:0]     sel;
    logic [DOUT_W-1:0]    dout;
    logic [SAFF_W-1:0]    saff;
    logic                 flush;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic [NSAMP_W-1:0]   nsamples;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    modport master (
        input  start, sample, sel, dout, saff, flush,
        output wr_en, wr_addr, wr_data, nsamples, busy, done, overflow
    );

    modport slave (
        output start, sample, sel, dout, saff, flush,
        input  wr_en, wr_addr, wr_data, nsamples, busy, done, overflow
    );

endinterface

// File: rtl/tdc_sample_packer_thermo_decode.sv
// Thermometer decoder for the SAFF inverter-chain sample.
// fine counts the unbroken run of ones starting at bit 0; bubble flags any one seen above the first zero.
module tdc_thermo_decode
    import tdc_sample_packer_pkg::*;
(
    input  logic [SAFF_W-1:0] saff,
    output logic [FINE_W-1:0] fine,
    output logic              bubble
);

    logic seen_zero_s;

    // Walk the chain from the first stage, counting ones until the first zero, then watch for stray ones.
    always_comb begin
        fine        = 5'd0;
        bubble      = 1'b0;
        seen_zero_s = 1'b0;
        for (int i = 0; i < SAFF_W; i++) begin
            if (!seen_zero_s) begin
                if (saff[i]) begin
                    fine = fine + 5'd1;
                end else begin
                    seen_zero_s = 1'b1;
                end
            end else begin
                if (saff[i]) begin
                    bubble = 1'b1;
                end else begin
                    bubble = bubble;
                end
            end
        end
    end

endmodule

// File: rtl/tdc_sample_packer.sv
// TDC sample packer: captures one readout per sample strobe, packs it into three datamem
// words at addresses 1..30 and closes the frame with a header word at address 0.
// A one-deep pending slot lets a strobe that lands during emission go out right after it.
module tdc_sample_packer
    import tdc_sample_packer_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    tdc_sample_packer_if.master        bus
);

    state_t               state_r,      state_nxt_s;
    logic [SEL_W-1:0]     cap_sel_r,    cap_sel_nxt_s;
    logic [DOUT_W-1:0]    cap_dout_r,   cap_dout_nxt_s;
    logic [SAFF_W-1:0]    cap_saff_r,   cap_saff_nxt_s;
    logic                 pend_valid_r, pend_valid_nxt_s;
    logic [SEL_W-1:0]     pend_sel_r,   pend_sel_nxt_s;
    logic [DOUT_W-1:0]    pend_dout_r,  pend_dout_nxt_s;
    logic [SAFF_W-1:0]    pend_saff_r,  pend_saff_nxt_s;
    logic                 flush_lat_r,  flush_lat_nxt_s;
    logic [ADDR_W-1:0]    ptr_r,        ptr_nxt_s;
    logic [NSAMP_W-1:0]   acc_r,        acc_nxt_s;
    logic [NSAMP_W-1:0]   nsamp_r,      nsamp_nxt_s;
    logic                 ovf_r,        ovf_nxt_s;
    logic                 done_r,       done_nxt_s;
    logic                 busy_r,       busy_nxt_s;
    logic                 wr_en_r,      wr_en_nxt_s;
    logic [ADDR_W-1:0]    wr_addr_r,    wr_addr_nxt_s;
    logic [DATA_W-1:0]    wr_data_r,    wr_data_nxt_s;

    logic [FINE_W-1:0]    fine_s;
    logic                 bubble_s;
    logic                 room_s;

    tdc_thermo_decode u_decode (
        .saff   (cap_saff_r),
        .fine   (fine_s),
        .bubble (bubble_s)
    );

    // acc_r counts every accepted sample (in flight or pending), so it bounds the frame at 10.
    assign room_s = (acc_r < MAX_SAMPLES);

    // Next-state, capture and write-port decisions; outputs are computed for the following cycle.
    always_comb begin
        state_nxt_s      = state_r;
        cap_sel_nxt_s    = cap_sel_r;
        cap_dout_nxt_s   = cap_dout_r;
        cap_saff_nxt_s   = cap_saff_r;
        pend_valid_nxt_s = pend_valid_r;
        pend_sel_nxt_s   = pend_sel_r;
        pend_dout_nxt_s  = pend_dout_r;
        pend_saff_nxt_s  = pend_saff_r;
        flush_lat_nxt_s  = flush_lat_r;
        ptr_nxt_s        = ptr_r;
        acc_nxt_s        = acc_r;
        nsamp_nxt_s      = nsamp_r;
        ovf_nxt_s        = ovf_r;
        done_nxt_s       = done_r;
        wr_en_nxt_s      = 1'b0;
        wr_addr_nxt_s    = 5'd0;
        wr_data_nxt_s    = 16'h0000;

        if (bus.start) begin
            state_nxt_s      = ST_ARMED;
            pend_valid_nxt_s = 1'b0;
            flush_lat_nxt_s  = 1'b0;
            ptr_nxt_s        = FIRST_DATA_ADDR;
            acc_nxt_s        = 4'd0;
            nsamp_nxt_s      = 4'd0;
            ovf_nxt_s        = 1'b0;
            done_nxt_s       = 1'b0;
        end else begin
            case (state_r)
                ST_ARMED: begin
                    if (bus.sample && room_s) begin
                        cap_sel_nxt_s   = bus.sel;
                        cap_dout_nxt_s  = bus.dout;
                        cap_saff_nxt_s  = bus.saff;
                        acc_nxt_s       = acc_r + 4'd1;
                        flush_lat_nxt_s = bus.flush;
                        state_nxt_s     = ST_E0;
                        wr_en_nxt_s     = 1'b1;
                        wr_addr_nxt_s   = ptr_r;
                        wr_data_nxt_s   = pack_word0(bus.sel, bus.dout);
                    end else begin
                        if (bus.sample) begin
                            ovf_nxt_s = 1'b1;
                        end else begin
                            ovf_nxt_s = ovf_r;
                        end
                        if (bus.flush) begin
                            state_nxt_s   = ST_HDR;
                            wr_en_nxt_s   = 1'b1;
                            wr_addr_nxt_s = HEADER_ADDR;
                            wr_data_nxt_s = pack_header(ovf_nxt_s, nsamp_r);
                        end else begin
                            state_nxt_s = ST_ARMED;
                        end
                    end
                end

                ST_E0, ST_E1: begin
                    if (bus.sample) begin
                        if (pend_valid_r || !room_s) begin
                            ovf_nxt_s = 1'b1;
                        end else begin
                            pend_valid_nxt_s = 1'b1;
                            pend_sel_nxt_s   = bus.sel;
                            pend_dout_nxt_s  = bus.dout;
                            pend_saff_nxt_s  = bus.saff;
                            acc_nxt_s        = acc_r + 4'd1;
                        end
                    end else begin
                        ovf_nxt_s = ovf_r;
                    end
                    if (bus.flush) begin
                        flush_lat_nxt_s = 1'b1;
                    end else begin
                        flush_lat_nxt_s = flush_lat_r;
                    end
                    wr_en_nxt_s   = 1'b1;
                    wr_addr_nxt_s = wr_addr_r + 5'd1;
                    if (state_r == ST_E0) begin
                        state_nxt_s   = ST_E1;
                        wr_data_nxt_s = cap_saff_r[SAFF_LO_W-1:0];
                    end else begin
                        state_nxt_s   = ST_E2;
                        wr_data_nxt_s = pack_word2(bubble_s, fine_s, cap_saff_r[SAFF_W-1:SAFF_LO_W]);
                        nsamp_nxt_s   = nsamp_r + 4'd1;
                        ptr_nxt_s     = ptr_r + WORDS_PER_SAMP;
                    end
                end

                ST_E2: begin
                    if (bus.flush) begin
                        flush_lat_nxt_s = 1'b1;
                    end else begin
                        flush_lat_nxt_s = flush_lat_r;
                    end
                    if (pend_valid_r) begin
                        if (bus.sample) begin
                            ovf_nxt_s = 1'b1;
                        end else begin
                            ovf_nxt_s = ovf_r;
                        end
                        cap_sel_nxt_s    = pend_sel_r;
                        cap_dout_nxt_s   = pend_dout_r;
                        cap_saff_nxt_s   = pend_saff_r;
                        pend_valid_nxt_s = 1'b0;
                        state_nxt_s      = ST_E0;
                        wr_en_nxt_s      = 1'b1;
                        wr_addr_nxt_s    = ptr_r;
                        wr_data_nxt_s    = pack_word0(pend_sel_r, pend_dout_r);
                    end else if (bus.sample && room_s) begin
                        cap_sel_nxt_s  = bus.sel;
                        cap_dout_nxt_s = bus.dout;
                        cap_saff_nxt_s = bus.saff;
                        acc_nxt_s      = acc_r + 4'd1;
                        state_nxt_s    = ST_E0;
                        wr_en_nxt_s    = 1'b1;
                        wr_addr_nxt_s  = ptr_r;
                        wr_data_nxt_s  = pack_word0(bus.sel, bus.dout);
                    end else begin
                        if (bus.sample) begin
                            ovf_nxt_s = 1'b1;
                        end else begin
                            ovf_nxt_s = ovf_r;
                        end
                        if (flush_lat_r || bus.flush) begin
                            flush_lat_nxt_s = 1'b0;
                            state_nxt_s     = ST_HDR;
                            wr_en_nxt_s     = 1'b1;
                            wr_addr_nxt_s   = HEADER_ADDR;
                            wr_data_nxt_s   = pack_header(ovf_nxt_s, nsamp_r);
                        end else begin
                            state_nxt_s = ST_ARMED;
                        end
                    end
                end

                ST_HDR: begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = 1'b1;
                end

                ST_IDLE, ST_DONE: begin
                    state_nxt_s = state_r;
                end

                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end

        busy_nxt_s = (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_E0) ||
                     (state_nxt_s == ST_E1)    || (state_nxt_s == ST_E2) ||
                     (state_nxt_s == ST_HDR);
    end

    // State, capture/pending registers and registered outputs; reset aborts any write in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cap_sel_r    <= 4'd0;
            cap_dout_r   <= 7'd0;
            cap_saff_r   <= 21'd0;
            pend_valid_r <= 1'b0;
            pend_sel_r   <= 4'd0;
            pend_dout_r  <= 7'd0;
            pend_saff_r  <= 21'd0;
            flush_lat_r  <= 1'b0;
            ptr_r        <= FIRST_DATA_ADDR;
            acc_r        <= 4'd0;
            nsamp_r      <= 4'd0;
            ovf_r        <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= 5'd0;
            wr_data_r    <= 16'h0000;
        end else begin
            state_r      <= state_nxt_s;
            cap_sel_r    <= cap_sel_nxt_s;
            cap_dout_r   <= cap_dout_nxt_s;
            cap_saff_r   <= cap_saff_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            pend_sel_r   <= pend_sel_nxt_s;
            pend_dout_r  <= pend_dout_nxt_s;
            pend_saff_r  <= pend_saff_nxt_s;
            flush_lat_r  <= flush_lat_nxt_s;
            ptr_r        <= ptr_nxt_s;
            acc_r        <= acc_nxt_s;
            nsamp_r      <= nsamp_nxt_s;
            ovf_r        <= ovf_nxt_s;
            done_r       <= done_nxt_s;
            busy_r       <= busy_nxt_s;
            wr_en_r      <= wr_en_nxt_s;
            wr_addr_r    <= wr_addr_nxt_s;
            wr_data_r    <= wr_data_nxt_s;
        end
    end

    assign bus.wr_en    = wr_en_r;
    assign bus.wr_addr  = wr_addr_r;
    assign bus.wr_data  = wr_data_r;
    assign bus.nsamples = nsamp_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_tdc_sample_packer.sv
// Directed bench for tdc_sample_packer: drives readout strobes, logs every datamem write
// and compares against hand-computed words, addresses and status flags.
module tb_tdc_sample_packer;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   passed;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];

    tdc_sample_packer_if bus_if();

    tdc_sample_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write seen by the datamem, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus_if.wr_en) begin
            wa.push_back({27'd0, bus_if.wr_addr});
            wd.push_back({16'd0, bus_if.wr_data});
            wc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] oa;
        logic [31:0] od;
        oa = (idx < wa.size()) ? wa[idx] : 32'hFFFF_FFFF;
        od = (idx < wd.size()) ? wd[idx] : 32'hFFFF_FFFF;
        chk({tag, "_addr"}, oa, addr);
        chk({tag, "_data"}, od, data);
    endtask

    task automatic pulse(input logic st, input logic sm, input logic fl,
                         input logic [3:0] sel, input logic [6:0] dout, input logic [20:0] saff);
        bus_if.start  = st;
        bus_if.sample = sm;
        bus_if.flush  = fl;
        bus_if.sel    = sel;
        bus_if.dout   = dout;
        bus_if.saff   = saff;
        @(posedge clk);
        #1;
        bus_if.start  = 1'b0;
        bus_if.sample = 1'b0;
        bus_if.flush  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    function automatic logic [31:0] outs();
        return {4'd0, bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data, bus_if.nsamples,
                bus_if.busy, bus_if.done, bus_if.overflow};
    endfunction

    // Guard against a stuck run.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc = 0; total = 0; passed = 0;
        reset = 1'b1;
        bus_if.start = 1'b0; bus_if.sample = 1'b0; bus_if.flush = 1'b0;
        bus_if.sel = 4'd0; bus_if.dout = 7'd0; bus_if.saff = 21'd0;
        idle(3);
        chk("reset_outputs", outs(), 32'd0);
        reset = 1'b0;
        idle(1);

        // Test 1: single sample, thermometer 0xFF -> fine 8
        pulse(1'b1, 1'b0, 1'b0, 4'd0, 7'd0, 21'd0);
        chk("start_busy", {31'd0, bus_if.busy}, 32'd1);
        clear_log();
        pulse(1'b0, 1'b1, 1'b0, 4'd3, 7'h45, 21'h0000FF);
        idle(4);
        chk("t1_nwrites", wa.size(), 32'd3);
        chk_wr("t1_w0", 0, 32'd1, 32'h8C45);
        chk_wr("t1_w1", 1, 32'd2, 32'h00FF);
        chk_wr("t1_w2", 2, 32'd3, 32'hC800);
        chk("t1_nsamples", {28'd0, bus_if.nsamples}, 32'd1);

        // Test 2: full chain and bubbled chain, then flush
        pulse(1'b0, 1'b1, 1'b0, 4'd5, 7'h12, 21'h1FFFFF);
        idle(3);
        pulse(1'b0, 1'b1, 1'b0, 4'hF, 7'h7F, 21'h000105);
        idle(4);
        chk_wr("t2a_w0", 3, 32'd4, 32'h9412);
        chk_wr("t2a_w1", 4, 32'd5, 32'hFFFF);
        chk_wr("t2a_w2", 5, 32'd6, 32'hD51F);
        chk_wr("t2b_w0", 6, 32'd7, 32'hBC7F);
        chk_wr("t2b_w1", 7, 32'd8, 32'h0105);
        chk_wr("t2b_w2", 8, 32'd9, 32'hE100);
        pulse(1'b0, 1'b0, 1'b1, 4'd0, 7'd0, 21'd0);
        idle(2);
        chk_wr("t2_hdr", 9, 32'd0, 32'hA003);
        chk("t2_done", {30'd0, bus_if.done, bus_if.busy}, 32'd2);

        // Test 3: 12 samples spaced 4 cycles; last two dropped
        pulse(1'b1, 1'b0, 1'b0, 4'd0, 7'd0, 21'd0);
        chk("t3_start_clears", {28'd0, bus_if.nsamples}, 32'd0);
        clear_log();
        for (int k = 1; k <= 12; k++) begin
            logic [20:0] th;
            th = 21'h1FFFFF >> (21 - k);
            pulse(1'b0, 1'b1, 1'b0, k[3:0], k[6:0], th);
            idle(3);
        end
        chk("t3_nwrites", wa.size(), 32'd30);
        chk_wr("t3_s10_w0", 27, 32'd28, 32'hA80A);
        chk_wr("t3_s10_w2", 29, 32'd30, 32'hCA00);
        chk("t3_ovf_n", {27'd0, bus_if.overflow, bus_if.nsamples}, 32'h1A);
        pulse(1'b0, 1'b0, 1'b1, 4'd0, 7'd0, 21'd0);
        idle(2);
        chk_wr("t3_hdr", 30, 32'd0, 32'hA20A);
        chk("t3_done", {31'd0, bus_if.done}, 32'd1);

        // Test 4: back-to-back strobes, third one dropped
        pulse(1'b1, 1'b0, 1'b0, 4'd0, 7'd0, 21'd0);
        chk("t4_ovf_cleared", {30'd0, bus_if.overflow, bus_if.done}, 32'd0);
        clear_log();
        pulse(1'b0, 1'b1, 1'b0, 4'd1, 7'd1, 21'h000001);
        pulse(1'b0, 1'b1, 1'b0, 4'd2, 7'd2, 21'h000003);
        pulse(1'b0, 1'b1, 1'b0, 4'd3, 7'd3, 21'h000007);
        idle(8);
        chk("t4_nwrites", wa.size(), 32'd6);
        chk("t4_span", (wc.size() == 6) ? (wc[5] - wc[0]) : -1, 32'd5);
        chk_wr("t4_b_w0", 3, 32'd4, 32'h8802);
        chk_wr("t4_b_w2", 5, 32'd6, 32'hC200);
        chk("t4_ovf_n", {27'd0, bus_if.overflow, bus_if.nsamples}, 32'h12);

        // Test 5: start wins over sample/flush; flush during E1 closes after E2
        pulse(1'b1, 1'b1, 1'b1, 4'd6, 7'h33, 21'h000007);
        idle(3);
        chk("t5_nowrite", wa.size() - 6, 32'd0);
        chk("t5_state", {27'd0, bus_if.nsamples, bus_if.done}, 32'd0);
        clear_log();
        pulse(1'b0, 1'b1, 1'b0, 4'd6, 7'h33, 21'h000007);
        idle(1);
        pulse(1'b0, 1'b0, 1'b1, 4'd0, 7'd0, 21'd0);
        idle(3);
        chk("t5_nwrites", wa.size(), 32'd4);
        chk_wr("t5_w0", 0, 32'd1, 32'h9833);
        chk_wr("t5_w2", 2, 32'd3, 32'hC300);
        chk_wr("t5_hdr", 3, 32'd0, 32'hA001);
        chk("t5_hdr_adjacent", (wc.size() == 4) ? (wc[3] - wc[2]) : -1, 32'd1);
        chk("t5_done", {31'd0, bus_if.done}, 32'd1);

        // Test 6: reset at E1 aborts emission; next frame restarts at address 1
        pulse(1'b1, 1'b0, 1'b0, 4'd0, 7'd0, 21'd0);
        clear_log();
        pulse(1'b0, 1'b1, 1'b0, 4'd7, 7'h11, 21'h00000F);
        idle(1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_reset_outputs", outs(), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("t6_aborted_writes", wa.size(), 32'd2);
        clear_log();
        pulse(1'b1, 1'b0, 1'b0, 4'd0, 7'd0, 21'd0);
        pulse(1'b0, 1'b1, 1'b0, 4'd8, 7'h22, 21'h000003);
        idle(4);
        chk("t6_nwrites", wa.size(), 32'd3);
        chk_wr("t6_w0", 0, 32'd1, 32'hA022);
        chk_wr("t6_w2", 2, 32'd3, 32'hC200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
